// File: rtl/coso_sample_packer_fifo_if.sv
// COSO sampler / UART-sender handshake bundle.
// master: sampler + sender side; slave: the packer.
//
// Signals:
//   CSReq           sample strobe (master -> slave)
//   CSCnt           sampler counter value (master -> slave)
//   is_transmitting sender busy (master -> slave)
//   tx_byte         byte for the sender (slave -> master)
//   transmit        one-cycle tx_byte valid pulse (slave -> master)
interface coso_sample_packer_fifo_if #(
  parameter int CNT_W = 16
);
  logic             CSReq;
  logic [CNT_W-1:0] CSCnt;
  logic             is_transmitting;
  logic [7:0]       tx_byte;
  logic             transmit;

  modport master (
    output CSReq, CSCnt, is_transmitting,
    input  tx_byte, transmit
  );

  modport slave (
    input  CSReq, CSCnt, is_transmitting,
    output tx_byte, transmit
  );
endinterface

// File: rtl/coso_sample_packer_fifo.sv
// COSO TRNG sample packer: NBLSB bits/sample into bytes, FIFO,
// and a drain FSM feeding a UART sender.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bus         coso_sample_packer_fifo_if.slave
//               (CSReq, CSCnt, is_transmitting, tx_byte, transmit)
//   clr_ovf     synchronous clear of overflow (and drop_cnt)
//   fifo_level  bytes currently stored
//   overflow    sticky: a completed byte was dropped
//   drop_cnt    (only with COSO_PACKER_DROPCNT_EN) saturating
//               count of dropped bytes
//
// Optional macro: COSO_PACKER_DROPCNT_EN adds drop_cnt.
module coso_sample_packer_fifo #(
  parameter int NBLSB   = 1,
  parameter int CNT_W   = 16,
  parameter int DEPTH   = 16,
  parameter int BUSY_TO = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  coso_sample_packer_fifo_if.slave bus,
  input  logic                     clr_ovf,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
`ifdef COSO_PACKER_DROPCNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int NBIT = 8 / NBLSB;
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int TW   = (BUSY_TO < 1) ? 1 : $clog2(BUSY_TO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  logic [2:0]    r_it;
  logic [7:0]    r_shift;
  logic [7:0]    w_byte;
  logic          w_last;
  logic          w_push_req;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_to;
  logic [7:0]    r_tx_byte;
  logic          r_transmit;
  logic          r_ovf;

  if (CNT_W > NBLSB) begin : g_unused
    logic w_unused;
    assign w_unused = ^bus.CSCnt[CNT_W-1:NBLSB];
  end

  // Byte as it stands after merging the current sample, so the
  // completing sample lands in the pushed byte on the same edge.
  always_comb begin
    w_byte = r_shift;
    w_byte[int'(r_it)*NBLSB +: NBLSB] = bus.CSCnt[NBLSB-1:0];
  end

  assign w_last     = (r_it == 3'(NBIT - 1));
  assign w_push_req = bus.CSReq & w_last;
  // Full is judged on the pre-pop level: a same-cycle pop
  // does not rescue a push into a full FIFO.
  assign w_full     = (r_level == LW'(DEPTH));
  assign w_push     = w_push_req & ~w_full;
  assign w_drop     = w_push_req & w_full;
  assign w_pop      = (r_state == S_IDLE)
                    & (r_level != '0)
                    & ~bus.is_transmitting;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_it    <= '0;
      r_shift <= '0;
    end else if (bus.CSReq) begin
      r_shift <= w_byte;
      r_it    <= w_last ? 3'd0 : r_it + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_pop) w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.is_transmitting)
          w_state_nxt = S_WAIT_DONE;
        else if (r_to == TW'(BUSY_TO))
          w_state_nxt = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (!bus.is_transmitting) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_to counts cycles spent in WAIT_BUSY; it restarts from 0
  // on every entry so a silent sender costs BUSY_TO+1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_to       <= '0;
      r_tx_byte  <= '0;
      r_transmit <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_transmit <= w_pop;
      if (w_pop) r_tx_byte <= r_mem[r_rptr];
      if ((r_state == S_WAIT_BUSY)
          && (w_state_nxt == S_WAIT_BUSY))
        r_to <= r_to + 1'b1;
      else
        r_to <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

`ifdef COSO_PACKER_DROPCNT_EN
  logic [15:0] r_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_drop) begin
      if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end else if (clr_ovf) begin
      r_drop <= '0;
    end
  end

  assign drop_cnt = r_drop;
`endif

  assign bus.tx_byte  = r_tx_byte;
  assign bus.transmit = r_transmit;
  assign fifo_level   = r_level;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_coso_sample_packer_fifo.sv
// Bench for coso_sample_packer_fifo: queue-based model plus
// directed literal checks on NBLSB=1, 4 and 8 instances.
module tb_coso_sample_packer_fifo;

  localparam int DEPTH   = 16;
  localparam int BUSY_TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic clr_ovf;
  logic zero_l;
  always #5 clk = ~clk;

  coso_sample_packer_fifo_if #(.CNT_W(16)) bus1 ();
  coso_sample_packer_fifo_if #(.CNT_W(16)) bus4 ();
  coso_sample_packer_fifo_if #(.CNT_W(16)) bus8 ();

  logic [4:0] lvl1, lvl4, lvl8;
  logic       ovf1, ovf4, ovf8;
`ifdef COSO_PACKER_DROPCNT_EN
  logic [15:0] drop1, drop4, drop8;
`endif

  coso_sample_packer_fifo #(
    .NBLSB(1), .CNT_W(16), .DEPTH(DEPTH), .BUSY_TO(BUSY_TO)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .clr_ovf(clr_ovf), .fifo_level(lvl1), .overflow(ovf1)
`ifdef COSO_PACKER_DROPCNT_EN
    , .drop_cnt(drop1)
`endif
  );

  coso_sample_packer_fifo #(
    .NBLSB(4), .CNT_W(16), .DEPTH(DEPTH), .BUSY_TO(BUSY_TO)
  ) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave),
    .clr_ovf(zero_l), .fifo_level(lvl4), .overflow(ovf4)
`ifdef COSO_PACKER_DROPCNT_EN
    , .drop_cnt(drop4)
`endif
  );

  coso_sample_packer_fifo #(
    .NBLSB(8), .CNT_W(16), .DEPTH(DEPTH), .BUSY_TO(BUSY_TO)
  ) dut8 (
    .clk(clk), .rst(rst), .bus(bus8.slave),
    .clr_ovf(zero_l), .fifo_level(lvl8), .overflow(ovf8)
`ifdef COSO_PACKER_DROPCNT_EN
    , .drop_cnt(drop8)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Sender: 0 never busy, 1 always busy, 2 busy 10 cycles
  // after each transmit pulse.
  int snd_mode = 0;
  int busy     = 0;
  always @(negedge clk) begin
    if (snd_mode == 1) begin
      bus1.is_transmitting = 1'b1;
    end else if (snd_mode == 2) begin
      if (bus1.transmit) busy = 10;
      else if (busy > 0) busy--;
      bus1.is_transmitting = (busy > 0);
    end else begin
      busy = 0;
      bus1.is_transmitting = 1'b0;
    end
  end

  // Model: bits accumulate LSB-first into a byte; every
  // 8th sample the byte joins q unless q holds DEPTH bytes.
  logic [7:0] q[$];
  logic [7:0] m_acc;
  int         m_n;
  bit         m_ovf;
  int         m_drop;
  bit         m_dropnow;
  logic [7:0] m_last;
  bit         m_prev_tx;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_acc     = 8'h00;
      m_n       = 0;
      m_ovf     = 0;
      m_drop    = 0;
      m_last    = 8'h00;
      m_prev_tx = 0;
    end else begin
      m_dropnow = 0;
      if (bus1.CSReq) begin
        m_acc[m_n] = bus1.CSCnt[0];
        m_n++;
        if (m_n == 8) begin
          if (q.size() == DEPTH) m_dropnow = 1;
          else q.push_back(m_acc);
          m_n   = 0;
          m_acc = 8'h00;
        end
      end
      if (m_dropnow) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end else if (clr_ovf) begin
        m_ovf  = 0;
        m_drop = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (bus1.transmit) begin
        if (q.size() == 0) begin
          chk("tx_unexpected", 32'd1, 32'd0);
        end else begin
          chk("tx_byte", bus1.tx_byte, q[0]);
          m_last = q.pop_front();
        end
        chk("tx_pulse_width", m_prev_tx, 0);
      end else begin
        chk("tx_hold", bus1.tx_byte, m_last);
      end
      m_prev_tx = bus1.transmit;
      chk("fifo_level", lvl1, q.size());
      chk("overflow", ovf1, m_ovf);
`ifdef COSO_PACKER_DROPCNT_EN
      chk("drop_cnt", drop1, m_drop);
`endif
    end
  end

  task automatic smp(input logic b, input logic c);
    @(negedge clk);
    bus1.CSReq = 1'b1;
    bus1.CSCnt = {15'd0, b};
    clr_ovf    = c;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus1.CSReq = 1'b0;
      clr_ovf    = 1'b0;
    end
  endtask

  task automatic push_byte(input logic [7:0] b,
                           input logic clr_last);
    for (int i = 0; i < 8; i++)
      smp(b[i], clr_last && (i == 7));
  endtask

  task automatic wait_tx(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      bus1.CSReq = 1'b0;
      clr_ovf    = 1'b0;
      if (bus1.transmit) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_tx_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    bit   bits [8];
    int   t_prev;
    int   cnt4, cnt8;
    logic [7:0] first8;
    rst          = 1'b1;
    clr_ovf      = 1'b0;
    zero_l       = 1'b0;
    bus1.CSReq   = 1'b0;
    bus1.CSCnt   = '0;
    bus4.CSReq   = 1'b0;
    bus4.CSCnt   = '0;
    bus4.is_transmitting = 1'b0;
    bus8.CSReq   = 1'b0;
    bus8.CSCnt   = '0;
    bus8.is_transmitting = 1'b0;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1;
    chk("rst_level", lvl1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_transmit", bus1.transmit, 0);
    chk("rst_tx_byte", bus1.tx_byte, 0);

    // NBLSB=1: bits 1,0,1,1,0,0,1,0 -> 8'h4D
    bits = '{1, 0, 1, 1, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) smp(bits[i], 1'b0);
    idle(1);
    chk("lat_level_after_push", lvl1, 1);
    chk("lat_no_tx_yet", bus1.transmit, 0);
    idle(1);
    chk("lat_transmit", bus1.transmit, 1);
    chk("lat_tx_4D", bus1.tx_byte, 8'h4D);
    chk("lat_level_drained", lvl1, 0);
    idle(12);

    // NBLSB=4 and NBLSB=8 instances
    cnt4   = 0;
    cnt8   = 0;
    first8 = 8'h00;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus4.transmit) cnt4++;
      if (bus8.transmit) begin
        if (cnt8 == 0) first8 = bus8.tx_byte;
        cnt8++;
      end
      bus4.CSReq = (i == 0) || (i == 1);
      bus4.CSCnt = (i == 0) ? 16'h00A3 : 16'h005C;
      bus8.CSReq = (i == 0) || (i == 10);
      bus8.CSCnt = (i == 0) ? 16'h12F7 : 16'h0034;
    end
    chk("n4_pulses", cnt4, 1);
    chk("n4_tx_C3", bus4.tx_byte, 8'hC3);
    chk("n4_level", lvl4, 0);
    chk("n8_pulses", cnt8, 2);
    chk("n8_first_F7", first8, 8'hF7);
    chk("n8_second_34", bus8.tx_byte, 8'h34);

    // Fill with a stalled sender, then overflow.
    snd_mode = 1;
    idle(2);
    for (int b = 0; b < DEPTH; b++)
      push_byte(8'(b * 37 + 5), 1'b0);
    idle(1);
    chk("full_level16", lvl1, 16);
    chk("full_no_ovf", ovf1, 0);
    push_byte(8'hEE, 1'b0);
    idle(1);
    chk("ovf_set", ovf1, 1);
    chk("ovf_level16", lvl1, 16);
`ifdef COSO_PACKER_DROPCNT_EN
    chk("drop_one", drop1, 1);
`endif
    push_byte(8'hDD, 1'b1);
    idle(1);
    chk("ovf_set_wins", ovf1, 1);
`ifdef COSO_PACKER_DROPCNT_EN
    chk("drop_two", drop1, 2);
`endif
    @(negedge clk);
    clr_ovf = 1'b1;
    idle(1);
    chk("ovf_cleared", ovf1, 0);

    // Release: silent sender, one byte per BUSY_TO+2 cycles.
    snd_mode = 0;
    t_prev   = 0;
    for (int k = 0; k < DEPTH; k++) begin
      wait_tx(40, ok);
      if (ok && k > 0)
        chk("tx_period", cyc - t_prev, BUSY_TO + 2);
      t_prev = cyc;
    end
    idle(3);
    chk("drained_level", lvl1, 0);
    idle(10);

    // Reset in WAIT_DONE with 3 of 8 samples pending.
    snd_mode = 2;
    idle(2);
    push_byte(8'h3C, 1'b0);
    wait_tx(10, ok);
    smp(1'b1, 1'b0);
    smp(1'b1, 1'b0);
    smp(1'b1, 1'b0);
    @(negedge clk);
    bus1.CSReq = 1'b0;
    chk("pre_rst_busy", bus1.is_transmitting, 1);
    rst      = 1'b1;
    snd_mode = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_level", lvl1, 0);
    chk("rst2_ovf", ovf1, 0);
    chk("rst2_transmit", bus1.transmit, 0);
    chk("rst2_tx_byte", bus1.tx_byte, 0);
    push_byte(8'hA4, 1'b0);
    wait_tx(10, ok);
    chk("fresh_byte_A4", bus1.tx_byte, 8'hA4);
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coso_sample_packer_fifo.md
Name: coso_sample_packer_fifo

Overview:
- Next-generation sample-to-transmit controller for the COSO TRNG.
- Packs the NBLSB least significant bits of each coherent-sampler counter value into bytes, LSB-first.
- Completed bytes are buffered in a FIFO so sampling never stalls while the UART sender is busy.
- A small FSM drains the FIFO to the sender through a transmit / is_transmitting handshake, and a sticky flag reports lost bytes.

Parameters:
- NBLSB, 1, bits taken per sample; legal values 1, 2, 4, 8. NBIT = 8/NBLSB samples per byte.
- CNT_W, 16, width of the CSCnt input; must be at least NBLSB.
- DEPTH, 16, FIFO depth in bytes; power of two, at least 2.
- BUSY_TO, 4, cycles the FSM waits for is_transmitting to rise before abandoning the handshake.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- CSReq  in  1  single-cycle strobe: CSCnt is stable and valid this cycle.
- CSCnt  in  CNT_W  coherent-sampler counter value.
- is_transmitting  in  1  high while the sender is busy.
- clr_ovf  in  1  synchronous clear of overflow.
- tx_byte  out  8  byte presented to the sender.
- transmit  out  1  one-cycle pulse: tx_byte is valid.
- fifo_level  out  $clog2(DEPTH)+1  number of bytes stored.
- overflow  out  1  sticky: at least one completed byte was dropped.

Behaviour:
- Reset: all of the following return to 0 — it, shift register, FIFO pointers, fifo_level, tx_byte, transmit, overflow. FSM goes to IDLE. Reset mid-handshake or mid-byte discards partial data.
- Packing:
  - Sampling is independent of is_transmitting.
  - Each cycle with CSReq=1: shift[it*NBLSB +: NBLSB] <= CSCnt[NBLSB-1:0], then it <= it+1, wrapping at NBIT.
  - When it==NBIT-1: the assembled byte, including the current sample, is pushed into the FIFO on that same edge, and it <= 0.
- Push and full:
  - Full is evaluated before any same-cycle pop.
  - A push while full is discarded and sets overflow. The packer continues; it still wraps.
  - A push and a pop in the same cycle when not full leaves fifo_level unchanged.
- overflow: set by a dropped push, cleared by clr_ovf. If set and clear occur in the same cycle, set wins.
- Drain FSM:
  - IDLE: if fifo_level>0 and is_transmitting=0, then tx_byte <= FIFO head, pop, transmit <= 1, go to WAIT_BUSY.
  - WAIT_BUSY: transmit <= 0. When is_transmitting=1, go to WAIT_DONE. After BUSY_TO cycles without it, go to IDLE; the byte counts as sent.
  - WAIT_DONE: when is_transmitting=0, go to IDLE.
- Latency: a byte pushed at edge N into an empty FIFO with the sender idle gives transmit=1 in the cycle after edge N+1, with tx_byte valid in that same cycle.
- tx_byte holds its value until the next pop.
- fifo_level is a registered count equal to pushes minus pops. The pointers wrap modulo DEPTH.

Optional Feature:
- Macro: COSO_PACKER_DROPCNT_EN.
- Defined:
  - Adds output drop_cnt [15:0], reset to 0.
  - Increments on every discarded push and saturates at 16'hFFFF.
  - Cleared by clr_ovf, using the same priority as overflow (increment wins).
- Undefined: no port and no counter logic. overflow behaves identically in both builds.

Test Plan:
- NBLSB=1: 8 CSReq pulses with CSCnt[0] = 1,0,1,1,0,0,1,0 and is_transmitting=0 -> one transmit pulse, tx_byte=8'h4D, fifo_level returns to 0.
- NBLSB=4: CSCnt=16'h00A3 then 16'h005C -> tx_byte=8'hC3. NBLSB=8: CSCnt=16'h12F7 -> tx_byte=8'hF7 after every sample.
- Hold is_transmitting=1 and push 16 bytes with DEPTH=16 -> fifo_level=16, overflow=0. The 17th byte -> overflow=1, fifo_level stays 16; with DROPCNT, drop_cnt=1. Releasing the sender -> the first 16 bytes are emitted in order.
- Sender that never raises is_transmitting -> transmit pulses every BUSY_TO+2 cycles until the FIFO is empty; no hang.
- Assert rst after 3 of 8 samples and during WAIT_DONE -> all outputs 0. The next 8 samples form a fresh byte with no stale bits.
- clr_ovf and an overflowing push in the same cycle -> overflow stays 1.
